// File: rtl/ip_port_arb_if.sv
// ip_port_arb_if: IP-channel request bundle plus RAM secondary-port signals.
// The arbiter takes the slave view; channels and RAM take the master view.
interface ip_port_arb_if #(
    parameter int NCH = 4,
    parameter int AW  = 10,
    parameter int DW  = 32,
    parameter int LW  = 3
);
    logic [NCH-1:0]    REQ;
    logic [NCH-1:0]    WR;
    logic [NCH*AW-1:0] ADDR;
    logic [NCH*LW-1:0] LEN;
    logic [NCH*DW-1:0] WDATA;
    logic [NCH-1:0]    GNT;
    logic [NCH-1:0]    RVALID;
    logic [DW-1:0]     RDATA;
    logic [NCH-1:0]    DONE;
    logic              MCSN;
    logic              MWEN;
    logic [AW-1:0]     MA;
    logic [DW-1:0]     MDI;
    logic [DW-1:0]     MDOUT;

    modport slave (
        input  REQ, WR, ADDR, LEN, WDATA, MDOUT,
        output GNT, RVALID, RDATA, DONE,
        output MCSN, MWEN, MA, MDI
    );

    modport master (
        output REQ, WR, ADDR, LEN, WDATA, MDOUT,
        input  GNT, RVALID, RDATA, DONE,
        input  MCSN, MWEN, MA, MDI
    );
endinterface

// File: rtl/ip_port_arb.sv
// ip_port_arb: N-channel burst arbiter/sequencer for the IP-side RAM port.
// Define IP_ARB_FIXED_PRIO_EN for fixed priority (lowest channel wins).
module ip_port_arb #(
    parameter int NCH = 4,
    parameter int AW  = 10,
    parameter int DW  = 32,
    parameter int LW  = 3
) (
    input logic          i_clk,
    input logic          i_rstn,
    ip_port_arb_if.slave bus
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [PW-1:0]  r_win;
    logic           r_wr;
    logic [AW-1:0]  r_addr;
    logic [LW-1:0]  r_len;
    logic [LW-1:0]  r_cnt;
    logic [NCH-1:0] r_rvalid;

    logic           w_any;
    logic [PW-1:0]  w_pick;
    logic           w_last;
    logic           w_end;
    logic [NCH-1:0] w_onehot;

    assign w_any    = |bus.REQ;
    assign w_last   = (r_cnt == r_len);
    assign w_onehot = NCH'(1) << r_win;
    assign w_end    = (r_state == S_BURST && w_last && r_wr) ||
                      (r_state == S_DRAIN);

`ifdef IP_ARB_FIXED_PRIO_EN
    always_comb begin
        w_pick = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (bus.REQ[i]) w_pick = PW'(i);
    end
`else
    logic [PW-1:0] r_ptr;
    int            w_idx;

    // Scan downward so the lowest offset from the pointer wins.
    always_comb begin
        w_pick = '0;
        w_idx  = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_idx = (int'(r_ptr) + i) % NCH;
            if (bus.REQ[w_idx]) w_pick = PW'(w_idx);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            r_ptr <= '0;
        else if (w_end)
            r_ptr <= (r_win == PW'(NCH - 1)) ? '0 : r_win + 1'b1;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_BURST;
            S_BURST: if (w_last)
                         w_state_nxt = r_wr ? S_IDLE : S_DRAIN;
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.GNT  = '0;
        bus.DONE = '0;
        bus.MCSN = 1'b1;
        bus.MWEN = 1'b1;
        bus.MA   = '0;
        bus.MDI  = '0;
        if (r_state == S_BURST) begin
            bus.GNT  = w_onehot;
            bus.MCSN = 1'b0;
            bus.MWEN = ~r_wr;
            bus.MA   = r_addr;
            bus.MDI  = bus.WDATA[int'(r_win)*DW +: DW];
            if (r_wr && w_last) bus.DONE = w_onehot;
        end
        if (r_state == S_DRAIN) bus.DONE = w_onehot;
    end

    // MDOUT is the RAM's registered output, valid in the RVALID cycle.
    assign bus.RVALID = r_rvalid;
    assign bus.RDATA  = (|r_rvalid) ? bus.MDOUT : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state  <= S_IDLE;
            r_win    <= '0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= (r_state == S_BURST && !r_wr) ? w_onehot : '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win  <= w_pick;
                        r_wr   <= bus.WR[w_pick];
                        r_addr <= bus.ADDR[int'(w_pick)*AW +: AW];
                        r_len  <= bus.LEN[int'(w_pick)*LW +: LW];
                        r_cnt  <= '0;
                    end
                end
                S_BURST: begin
                    r_addr <= r_addr + 1'b1;
                    r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ip_port_arb.sv
// tb_ip_port_arb: directed and random bursts against a transaction-level model
// of round-robin order, beat addresses, data and RAM contents.
module tb_ip_port_arb;
    localparam int NCH = 4;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LW  = 3;
    localparam int MSZ = 1 << AW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic init = 1'b0;

    always #5 clk = ~clk;

    ip_port_arb_if #(.NCH(NCH), .AW(AW), .DW(DW), .LW(LW)) bus ();

    ip_port_arb #(.NCH(NCH), .AW(AW), .DW(DW), .LW(LW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus.slave)
    );

    logic [DW-1:0] mem     [MSZ];
    logic [DW-1:0] exp_mem [MSZ];
    logic [DW-1:0] wbase   [NCH];
    logic          cwr     [NCH];
    int            caddr   [NCH];
    int            clen    [NCH];
    int            bcnt    [NCH];

    int checks   = 0;
    int failures = 0;
    int ptr      = 0;
    int next_lat = 1;

    function automatic logic [DW-1:0] seed(int a);
        return 32'h5A00_0000 ^ DW'(a * 65537);
    endfunction

    // Synchronous-read RAM on the secondary port.
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < MSZ; i++) mem[i] <= seed(i);
        end else if (!bus.MCSN) begin
            if (!bus.MWEN) mem[bus.MA] <= bus.MDI;
            else bus.MDOUT <= mem[bus.MA];
        end
    end

    // Each IP presents base+beat_index on its write data.
    always @(posedge clk)
        for (int c = 0; c < NCH; c++)
            if (!rstn || bus.DONE[c]) bcnt[c] <= 0;
            else if (bus.GNT[c]) bcnt[c] <= bcnt[c] + 1;

    always_comb
        for (int c = 0; c < NCH; c++)
            bus.WDATA[c*DW +: DW] = wbase[c] + DW'(bcnt[c]);

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(int c, logic w, int a, int l, logic [DW-1:0] b);
        cwr[c]   = w;
        caddr[c] = a;
        clen[c]  = l;
        wbase[c] = b;
        bus.WR[c] = w;
        bus.ADDR[c*AW +: AW] = AW'(a);
        bus.LEN[c*LW +: LW]  = LW'(l);
    endtask

    function automatic int rr_pick(logic [NCH-1:0] m, int p);
        for (int i = 0; i < NCH; i++)
            if (m[(p + i) % NCH]) return (p + i) % NCH;
        return 0;
    endfunction

    task automatic wait_beat(string tag, int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.GNT == '0 && n < 50);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
    endtask

    task automatic expect_burst(string tag, int ch, logic [NCH-1:0] dropm);
        logic [NCH-1:0] oh;
        logic [DW-1:0]  d;
        int a;
        oh = NCH'(1) << ch;
        wait_beat(tag, next_lat);
        for (int k = 0; k <= clen[ch]; k++) begin
            if (k > 0) @(negedge clk);
            a = (caddr[ch] + k) % MSZ;
            chk({tag, "_gnt"}, 64'(bus.GNT), 64'(oh));
            chk({tag, "_mcsn"}, 64'(bus.MCSN), 64'(0));
            chk({tag, "_mwen"}, 64'(bus.MWEN), 64'(!cwr[ch]));
            chk({tag, "_ma"}, 64'(bus.MA), 64'(a));
            if (cwr[ch]) begin
                d = wbase[ch] + DW'(k);
                chk({tag, "_mdi"}, 64'(bus.MDI), 64'(d));
                exp_mem[a] = d;
                chk({tag, "_rvalid"}, 64'(bus.RVALID), 64'(0));
            end else if (k > 0) begin
                chk({tag, "_rvalid"}, 64'(bus.RVALID), 64'(oh));
                chk({tag, "_rdata"}, 64'(bus.RDATA),
                    64'(exp_mem[(a + MSZ - 1) % MSZ]));
            end else begin
                chk({tag, "_rvalid"}, 64'(bus.RVALID), 64'(0));
            end
            chk({tag, "_done"}, 64'(bus.DONE),
                64'((cwr[ch] && k == clen[ch]) ? oh : '0));
        end
        bus.REQ = bus.REQ & ~dropm;
        @(negedge clk);
        chk({tag, "_post_gnt"}, 64'(bus.GNT), 64'(0));
        chk({tag, "_post_mcsn"}, 64'(bus.MCSN), 64'(1));
        if (cwr[ch]) begin
            chk({tag, "_post_done"}, 64'(bus.DONE), 64'(0));
            chk({tag, "_post_rv"}, 64'(bus.RVALID), 64'(0));
            next_lat = 1;
        end else begin
            a = (caddr[ch] + clen[ch]) % MSZ;
            chk({tag, "_drain_rv"}, 64'(bus.RVALID), 64'(oh));
            chk({tag, "_drain_rd"}, 64'(bus.RDATA), 64'(exp_mem[a]));
            chk({tag, "_drain_done"}, 64'(bus.DONE), 64'(oh));
            next_lat = 2;
        end
        ptr = (ch + 1) % NCH;
    endtask

    task automatic run_set(string tag);
        int w;
        while (bus.REQ != '0) begin
            w = rr_pick(bus.REQ, ptr);
            expect_burst(tag, w, NCH'(1) << w);
        end
    endtask

    initial begin
        logic [NCH-1:0] m;
        bus.REQ  = '0;
        bus.WR   = '0;
        bus.ADDR = '0;
        bus.LEN  = '0;
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b0, 0, 0, '0);
        for (int i = 0; i < MSZ; i++) exp_mem[i] = seed(i);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;

        // Reset held with every channel requesting.
        for (int c = 0; c < NCH; c++)
            set_ch(c, 1'b1, 'h100 + c * 16, 0, DW'('hC0 + c * 16));
        bus.REQ = '1;
        repeat (10) begin
            @(negedge clk);
            chk("rst_mcsn", 64'(bus.MCSN), 64'(1));
            chk("rst_gnt", 64'(bus.GNT), 64'(0));
            chk("rst_done", 64'(bus.DONE), 64'(0));
            chk("rst_rv", 64'(bus.RVALID), 64'(0));
        end
        rstn = 1'b1;
        ptr = 0;
        next_lat = 1;

        // Fairness: held requests rotate 0,1,2,3,0,1.
        for (int j = 0; j < 6; j++)
            expect_burst("fair", j % NCH, (j == 5) ? '1 : '0);

        set_ch(1, 1'b1, 'h010, 3, 32'hA0);
        bus.REQ = 4'b0010;
        run_set("wr1");
        for (int k = 0; k < 4; k++)
            chk("wr1_mem", 64'(mem['h010 + k]), 64'(32'hA0 + k));

        set_ch(2, 1'b0, 'h010, 3, '0);
        bus.REQ = 4'b0100;
        run_set("rd2");

        // Reset during the second beat of an 8-beat read.
        set_ch(2, 1'b0, 'h020, 7, '0);
        bus.REQ = 4'b0100;
        wait_beat("rstmid", next_lat);
        @(negedge clk);
        chk("rstmid_beat2", 64'(bus.GNT), 64'(4'b0100));
        rstn = 1'b0;
        bus.REQ = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_mcsn", 64'(bus.MCSN), 64'(1));
            chk("rstmid_gnt", 64'(bus.GNT), 64'(0));
            chk("rstmid_done", 64'(bus.DONE), 64'(0));
            chk("rstmid_rv", 64'(bus.RVALID), 64'(0));
        end
        set_ch(1, 1'b1, 'h030, 1, 32'h1100);
        set_ch(3, 1'b1, 'h040, 1, 32'h3300);
        bus.REQ = 4'b1010;
        rstn = 1'b1;
        ptr = 0;
        next_lat = 1;
        expect_burst("rstptr", 1, 4'b0010);
        expect_burst("rstptr", 3, 4'b1000);

        set_ch(3, 1'b1, 'h3FE, 2, 32'h7700);
        bus.REQ = 4'b1000;
        run_set("wrap");
        chk("wrap_m0", 64'(mem['h3FE]), 64'(32'h7700));
        chk("wrap_m1", 64'(mem['h3FF]), 64'(32'h7701));
        chk("wrap_m2", 64'(mem['h000]), 64'(32'h7702));

        set_ch(0, 1'b1, 'h050, 0, 32'h9900);
        bus.REQ = 4'b0001;
        run_set("len0");
        @(negedge clk);
        chk("len0_idle_gnt", 64'(bus.GNT), 64'(0));
        next_lat = 1;

        for (int r = 0; r < 25; r++) begin
            m = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int c = 0; c < NCH; c++)
                if (m[c])
                    set_ch(c, logic'($urandom_range(0, 1)),
                           int'($urandom_range(0, MSZ - 1)),
                           int'($urandom_range(0, (1 << LW) - 1)),
                           DW'($urandom));
            bus.REQ = m;
            run_set("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ip_port_arb.md
Name: ip_port_arb

Overview:
- Parametrised N-channel arbiter and burst sequencer for the secondary (IP-side) port of the dual-port data RAM.
- Successor to the single fixed IP-to-RAM connection: lets several custom IP blocks share that port.
- Each channel requests a read or write burst; the block arbitrates round-robin, drives the RAM's active-low chip-select/write-enable, increments addresses, and returns read data with valid strobes.

Parameters:
- NCH, 4, number of IP channels (1..8)
- AW, 10, RAM word-address width (matches A[11:2])
- DW, 32, data width
- LW, 3, burst-length field width; burst = LEN+1 beats, max 2^LW

Ports:
- CLK  in  1  system clock
- RSTN  in  1  synchronous active-low reset
- REQ  in  NCH  per-channel burst request, level
- WR  in  NCH  per-channel direction, 1=write, 0=read; sampled at grant
- ADDR  in  NCH*AW  per-channel start word address; sampled at grant
- LEN  in  NCH*LW  per-channel beats-minus-one; sampled at grant
- WDATA  in  NCH*DW  per-channel write data; consumed on each beat cycle
- GNT  out  NCH  one-hot beat strobe: high in each cycle a beat of that channel is issued
- RVALID  out  NCH  one-hot read-data valid
- RDATA  out  DW  read data, shared by all channels
- DONE  out  NCH  one-cycle pulse at end of a channel's burst
- MCSN  out  1  RAM chip select, active low
- MWEN  out  1  RAM write enable, active low
- MA  out  AW  RAM word address
- MDI  out  DW  RAM write data
- MDOUT  in  DW  RAM read data; valid the cycle after a read beat

Behaviour:
- Reset is synchronous and active-low: RSTN low at a rising CLK edge forces the reset state.
- Reset values: GNT=0, RVALID=0, DONE=0, RDATA=0, MCSN=1, MWEN=1, MA=0, MDI=0, state=IDLE, round-robin pointer=0.
- Reset mid-burst aborts the burst immediately. No DONE is issued. Any read data still in flight is discarded.
- State machine:
  - IDLE: if any REQ is high, pick the winner: first requesting channel at or after the pointer, wrapping modulo NCH. Latch WR, ADDR and LEN of the winner. Go to BURST. Arbitration takes one cycle, so the first beat comes the cycle after REQ is seen.
  - BURST: each cycle issue one beat: MCSN=0, MWEN=~WR, MA=current address, MDI=WDATA of the winner, GNT[winner]=1.
    - Address increments by 1 per beat and wraps modulo 2^AW (0x3FF to 0x000).
    - After beat LEN+1: a write goes to IDLE with DONE[winner] pulsed that same cycle; a read goes to DRAIN.
  - DRAIN: one cycle. RVALID[winner]=1 for the last beat, DONE[winner]=1. Go to IDLE.
- Read data: MDOUT registered into RDATA. RVALID[winner] is high exactly one cycle after each read beat; the last read's RVALID coincides with DRAIN.
- After each completed burst, the pointer = winner+1 mod NCH.
- REQ/WR/ADDR/LEN changes during a burst are ignored. Deasserting REQ mid-burst does not stop the burst.
- A channel still holding REQ after DONE competes again. Other requesters are ahead of it in round-robin order.
- LEN=0 gives a single beat.
- Outside BURST: MCSN=1, MWEN=1; GNT is never high.
- At most one bit of each of GNT, RVALID and DONE is high in any cycle.
- Throughput: a write burst of n beats occupies n+1 cycles including arbitration; a read burst occupies n+2.

Optional Feature:
- Macro: IP_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest channel index wins; the pointer is not used or updated.
- Undefined: round-robin as described above.

Test Plan:
- Reset: hold RSTN=0 for 10 cycles with REQ=4'b1111 -> MCSN=1, GNT=0, DONE=0 throughout; the first beat appears 2 cycles after RSTN rises (one cycle of IDLE arbitration, then BURST), to ch0.
- Single write: ch1 WR=1, ADDR=0x010, LEN=3, WDATA tracks beat index 0xA0..0xA3 -> MA=0x010..0x013, MWEN=0 on 4 consecutive cycles, GNT[1] on the same cycles, DONE[1] on the 4th beat; RAM holds 0xA0..0xA3.
- Read back: ch2 read ADDR=0x010, LEN=3 -> RVALID[2] on 4 cycles, each one cycle after its beat, RDATA=0xA0..0xA3, DONE[2] with the last RVALID.
- Fairness: all 4 channels hold REQ with LEN=0 -> grant order 0,1,2,3,0,1; with IP_ARB_FIXED_PRIO_EN defined -> 0,0,0,...
- Wrap and LEN=0: ADDR=0x3FE, LEN=2 write -> MA=0x3FE, 0x3FF, 0x000; separately LEN=0 -> exactly one GNT pulse.
- Reset mid-burst: RSTN=0 at beat 2 of an 8-beat read -> next cycle MCSN=1 and no DONE/RVALID; after release, the pointer restarts at ch0.
